frame_buffer_port: RTL and testbench

//  Responder end of the sprite-draw frame-buffer write interface. Accepts pixel

---
 rtl/frame_buffer_port.sv | 166 ++++++++++++++++
 tb/tb_frame_buffer_port.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_port.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_port
// Description : Responder end of the sprite-draw frame-buffer write port.
//               Arbitrates draw writes, display scan-out reads and a
//               full-screen clear onto one synchronous single-port pixel SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buffer_port #(
    parameter int unsigned FB_DEPTH    = 307200,
    parameter int unsigned RD_LAT      = 2,
    parameter int unsigned WR_STARVE   = 4,
    parameter logic [23:0] CLEAR_COLOR = 24'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write_en,
    input  logic [18:0] frame_addr,
    input  logic [23:0] frame_data,
    output logic        frame_write_valid,
    input  logic        disp_req,
    input  logic [18:0] disp_addr,
    output logic        disp_ready,
    output logic [23:0] disp_data,
    output logic        disp_data_valid,
    input  logic        clear_start,
    output logic        clear_busy,
    output logic        clear_done,
    output logic        addr_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [18:0] mem_addr,
    output logic [23:0] mem_wdata,
    input  logic [23:0] mem_rdata
);

    localparam int unsigned     C_SW         = $clog2(WR_STARVE + 2);
    localparam logic [18:0]     C_DEPTH      = 19'(FB_DEPTH);
    localparam logic [18:0]     C_LAST       = 19'(FB_DEPTH - 1);
    localparam logic [C_SW-1:0] C_STARVE_MAX = C_SW'(WR_STARVE);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [18:0]     r_clear_cnt;
    logic [18:0]     w_clear_cnt_next;
    logic            w_clear_done_next;
    logic            w_clear_accept;

    logic [C_SW-1:0] r_starve;
    logic [RD_LAT:0] r_rd_vld;
    logic [RD_LAT:0] r_rd_oor;

    logic            w_wr_pend;
    logic            w_forced;
    logic            w_gnt_wr;
    logic            w_gnt_rd;
    logic            w_gnt_clr;
    logic            w_wr_oor;
    logic            w_rd_oor;

    // A held request is not a new one while its ack is on the wire.
    assign w_wr_pend = write_en & ~frame_write_valid;
    assign w_forced  = w_wr_pend & (r_starve == C_STARVE_MAX);
    assign w_wr_oor  = (frame_addr >= C_DEPTH);
    assign w_rd_oor  = (disp_addr >= C_DEPTH);

    // Slot priority: starved draw write, display read, clear, draw write.
    assign w_gnt_rd  = ~w_forced & disp_req;
    assign w_gnt_clr = ~w_forced & ~disp_req & (r_state == S_CLEAR);
    assign w_gnt_wr  = w_forced | (w_wr_pend & ~disp_req & (r_state != S_CLEAR));

    // Held low in reset so the port presents all-zero outputs there.
    assign disp_ready = rst_n & ~w_forced;
    assign clear_busy = (r_state == S_CLEAR);

    // Clear FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_clear_cnt <= '0;
            clear_done  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_clear_cnt <= w_clear_cnt_next;
            clear_done  <= w_clear_done_next;
        end
    end

    // Clear FSM next state: walk every pixel once, finish on the last one.
    always_comb begin
        w_state_next      = r_state;
        w_clear_cnt_next  = r_clear_cnt;
        w_clear_done_next = 1'b0;
        w_clear_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clear_start) begin
                    w_state_next     = S_CLEAR;
                    w_clear_cnt_next = '0;
                    w_clear_accept   = 1'b1;
                end
            end
            S_CLEAR: begin
                if (w_gnt_clr) begin
                    if (r_clear_cnt == C_LAST) begin
                        w_state_next      = S_IDLE;
                        w_clear_done_next = 1'b1;
                    end else begin
                        w_clear_cnt_next = r_clear_cnt + 19'd1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Register the granted operation onto the SRAM port; track starvation and errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en            <= 1'b0;
            mem_we            <= 1'b0;
            mem_addr          <= '0;
            mem_wdata         <= '0;
            frame_write_valid <= 1'b0;
            r_starve          <= '0;
            addr_err          <= 1'b0;
        end else begin
            mem_en            <= (w_gnt_wr & ~w_wr_oor) | (w_gnt_rd & ~w_rd_oor) | w_gnt_clr;
            mem_we            <= (w_gnt_wr & ~w_wr_oor) | w_gnt_clr;
            mem_addr          <= w_gnt_clr ? r_clear_cnt : (w_gnt_rd ? disp_addr : frame_addr);
            mem_wdata         <= w_gnt_clr ? CLEAR_COLOR : frame_data;
            frame_write_valid <= w_gnt_wr;
            if (w_gnt_wr) begin
                r_starve <= '0;
            end else if (w_wr_pend && (r_starve != C_STARVE_MAX)) begin
                r_starve <= r_starve + 1'b1;
            end
            addr_err <= (addr_err & ~w_clear_accept)
                      | (w_gnt_wr & w_wr_oor) | (w_gnt_rd & w_rd_oor);
        end
    end

    // Read-return pipeline: tags follow each accepted read until its data arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld        <= '0;
            r_rd_oor        <= '0;
            disp_data_valid <= 1'b0;
            disp_data       <= '0;
        end else begin
            r_rd_vld        <= {r_rd_vld[RD_LAT-1:0], w_gnt_rd};
            r_rd_oor        <= {r_rd_oor[RD_LAT-1:0], w_gnt_rd & w_rd_oor};
            disp_data_valid <= r_rd_vld[RD_LAT];
            if (r_rd_vld[RD_LAT]) begin
                disp_data <= r_rd_oor[RD_LAT] ? 24'h0 : mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_buffer_port
// Description : Self-checking bench for frame_buffer_port: SRAM model,
//               transaction-level reference model, directed and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_buffer_port;

    localparam int          FB_DEPTH    = 512;
    localparam int          RD_LAT      = 2;
    localparam int          WR_STARVE   = 4;
    localparam logic [23:0] CLEAR_COLOR = 24'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write_en = 1'b0;
    logic [18:0] frame_addr = '0;
    logic [23:0] frame_data = '0;
    logic        frame_write_valid;
    logic        disp_req = 1'b0;
    logic [18:0] disp_addr = '0;
    logic        disp_ready;
    logic [23:0] disp_data;
    logic        disp_data_valid;
    logic        clear_start = 1'b0;
    logic        clear_busy;
    logic        clear_done;
    logic        addr_err;
    logic        mem_en;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    frame_buffer_port #(
        .FB_DEPTH    (FB_DEPTH),
        .RD_LAT      (RD_LAT),
        .WR_STARVE   (WR_STARVE),
        .CLEAR_COLOR (CLEAR_COLOR)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .write_en          (write_en),
        .frame_addr        (frame_addr),
        .frame_data        (frame_data),
        .frame_write_valid (frame_write_valid),
        .disp_req          (disp_req),
        .disp_addr         (disp_addr),
        .disp_ready        (disp_ready),
        .disp_data         (disp_data),
        .disp_data_valid   (disp_data_valid),
        .clear_start       (clear_start),
        .clear_busy        (clear_busy),
        .clear_done        (clear_done),
        .addr_err          (addr_err),
        .mem_en            (mem_en),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pat(input int i);
        return 24'h100000 + 24'(i);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- SRAM model: RD_LAT-cycle read latency ----------------
    logic [23:0] sram [FB_DEPTH];
    logic [23:0] rd_pipe [RD_LAT];
    bit          sram_inited = 1'b0;
    assign mem_rdata = rd_pipe[RD_LAT-1];

    always @(posedge clk) begin
        if (!sram_inited) begin
            for (int i = 0; i < FB_DEPTH; i++) sram[i] <= pat(i);
            sram_inited <= 1'b1;
        end else if (mem_en && mem_we && (int'(mem_addr) < FB_DEPTH)) begin
            sram[int'(mem_addr)] <= mem_wdata;
        end
        rd_pipe[0] <= (mem_en && !mem_we && (int'(mem_addr) < FB_DEPTH)) ?
                      sram[int'(mem_addr)] : 24'hDEAD00;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // ---------------- reference model (transaction level) ----------------
    typedef struct {
        int          due;
        logic [23:0] data;
    } rd_t;

    rd_t         rq[$];
    logic [23:0] m_mem [FB_DEPTH];
    bit          m_inited = 1'b0;
    int          cyc = 0;
    int          m_starve = 0;
    bit          m_busy = 1'b0;
    int          m_cnt = 0;
    bit          e_fwv = 1'b0, e_mem_en = 1'b0, e_we = 1'b0, e_done = 1'b0, e_err = 1'b0;
    logic [18:0] e_addr = '0;
    logic [23:0] e_wdata = '0;
    bit          pend, forced, gw, gr, gc, clr_acc, exp_dv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (!m_inited) begin
                for (int i = 0; i < FB_DEPTH; i++) m_mem[i] = pat(i);
                m_inited = 1'b1;
            end
            cyc = 0; m_starve = 0; m_busy = 1'b0; m_cnt = 0;
            e_fwv = 1'b0; e_mem_en = 1'b0; e_we = 1'b0; e_done = 1'b0; e_err = 1'b0;
            rq.delete();
        end else begin
            // Decide who owns this cycle's SRAM slot.
            pend   = write_en && !e_fwv;
            forced = pend && (m_starve == WR_STARVE);
            gw = 1'b0; gr = 1'b0; gc = 1'b0;
            if (forced)        gw = 1'b1;
            else if (disp_req) gr = 1'b1;
            else if (m_busy)   gc = 1'b1;
            else if (pend)     gw = 1'b1;
            clr_acc  = clear_start && !m_busy;
            e_fwv    = gw;
            e_mem_en = 1'b0;
            e_we     = 1'b0;
            e_done   = 1'b0;
            if (clr_acc) e_err = 1'b0;
            if (gw) begin
                if (int'(frame_addr) < FB_DEPTH) begin
                    e_mem_en = 1'b1; e_we = 1'b1; e_addr = frame_addr; e_wdata = frame_data;
                    m_mem[int'(frame_addr)] = frame_data;
                end else begin
                    e_err = 1'b1;
                end
                m_starve = 0;
            end else if (pend && m_starve < WR_STARVE) begin
                m_starve++;
            end
            if (gr) begin
                if (int'(disp_addr) < FB_DEPTH) begin
                    e_mem_en = 1'b1; e_addr = disp_addr;
                    rq.push_back('{due: cyc + 2 + RD_LAT, data: m_mem[int'(disp_addr)]});
                end else begin
                    e_err = 1'b1;
                    rq.push_back('{due: cyc + 2 + RD_LAT, data: 24'h0});
                end
            end
            if (gc) begin
                e_mem_en = 1'b1; e_we = 1'b1; e_addr = 19'(m_cnt); e_wdata = CLEAR_COLOR;
                m_mem[m_cnt] = CLEAR_COLOR;
                if (m_cnt == FB_DEPTH - 1) begin
                    m_busy = 1'b0; e_done = 1'b1;
                end else begin
                    m_cnt++;
                end
            end else if (clr_acc) begin
                m_busy = 1'b1; m_cnt = 0;
            end
            cyc++;
        end
    end

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            chk("frame_write_valid", frame_write_valid, e_fwv);
            chk("mem_en", mem_en, e_mem_en);
            if (e_mem_en) begin
                chk("mem_we", mem_we, e_we);
                chk("mem_addr", mem_addr, e_addr);
                if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
            end
            chk("disp_ready", disp_ready, !(write_en && !e_fwv && m_starve == WR_STARVE));
            chk("clear_busy", clear_busy, m_busy);
            chk("clear_done", clear_done, e_done);
            chk("addr_err", addr_err, e_err);
            exp_dv = (rq.size() > 0) && (rq[0].due == cyc);
            chk("disp_data_valid", disp_data_valid, exp_dv);
            if (exp_dv) begin
                chk("disp_data", disp_data, rq[0].data);
                void'(rq.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        write_en = 1'b0; disp_req = 1'b0; clear_start = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctl"}, {frame_write_valid, disp_ready, disp_data_valid, clear_busy,
                           clear_done, addr_err, mem_en, mem_we}, 0);
        chk({nm, "_mem_addr"}, mem_addr, 0);
        chk({nm, "_mem_wdata"}, mem_wdata, 0);
        chk({nm, "_disp_data"}, disp_data, 0);
    endtask

    int nack, nv, first, nstall, ack_k, nwr, nok, ndone, nz, wr_pct, rd_pct;
    logic [23:0] d3;
    bit busy_at_done;

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: held write, single ack one cycle later.
        nack = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            write_en = (k < 2); frame_addr = 19'd100; frame_data = 24'hABCDEF;
            #1;
            if (frame_write_valid) nack++;
            if (k == 1) begin
                chk("t1_ack", frame_write_valid, 1);
                chk("t1_we", {mem_en, mem_we}, 2'b11);
                chk("t1_addr", mem_addr, 100);
                chk("t1_data", mem_wdata, 24'hABCDEF);
            end
        end
        chk("t1_ack_count", nack, 1);

        // 2: eight back-to-back reads, first data 4 cycles after first request.
        nv = 0; first = -1; d3 = '0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            disp_req = (k < 8); disp_addr = 19'(k);
            #1;
            if (disp_data_valid) begin
                if (first < 0) first = k;
                if (nv == 3) d3 = disp_data;
                nv++;
            end
        end
        chk("t2_first_latency", first, 4);
        chk("t2_count", nv, 8);
        chk("t2_data3", d3, 24'h100003);

        // 3: reads every cycle starve a pending write for exactly WR_STARVE cycles.
        nstall = 0; first = -1; ack_k = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            disp_req = 1'b1; disp_addr = 19'(k);
            write_en = (ack_k < 0); frame_addr = 19'd200; frame_data = 24'h123456;
            #1;
            if (!disp_ready) begin
                nstall++;
                if (first < 0) first = k;
            end
            if (frame_write_valid) ack_k = k;
        end
        chk("t3_stall_at", first, 4);
        chk("t3_stall_cycles", nstall, 1);
        chk("t3_ack_at", ack_k, 5);
        @(negedge clk); idle_inputs();
        repeat (8) @(negedge clk);

        // 4: out-of-range write is acked without touching the SRAM.
        @(negedge clk);
        write_en = 1'b1; frame_addr = 19'd307200; frame_data = 24'h777777;
        @(negedge clk);
        #1;
        chk("t4_ack", frame_write_valid, 1);
        chk("t4_no_mem_en", mem_en, 0);
        chk("t4_addr_err", addr_err, 1);
        @(negedge clk);
        write_en = 1'b0; clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        #1;
        chk("t4_err_cleared", addr_err, 0);
        chk("t4_busy", clear_busy, 1);

        // 5: full clear with no other traffic.
        nwr = 0; nok = 0; ndone = 0; busy_at_done = 1'b1;
        for (int k = 0; k < FB_DEPTH + 20; k++) begin
            @(negedge clk);
            #1;
            if (mem_en && mem_we) begin
                if (int'(mem_addr) == nwr && mem_wdata == CLEAR_COLOR) nok++;
                nwr++;
            end
            if (clear_done) begin
                ndone++;
                busy_at_done = clear_busy;
            end
        end
        chk("t5_writes", nwr, FB_DEPTH);
        chk("t5_in_order", nok, FB_DEPTH);
        chk("t5_done_pulses", ndone, 1);
        chk("t5_busy_at_done", busy_at_done, 0);
        nz = 0;
        for (int i = 0; i < FB_DEPTH; i++) if (sram[i] != CLEAR_COLOR) nz++;
        chk("t5_sram_cleared", nz, 0);

        // 6: reset in the middle of a clear with reads in flight.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            write_en    = (k == 0);
            frame_addr  = 19'd5; frame_data = 24'hFEDCBA;
            clear_start = (k == 2);
            disp_req    = (k >= 2);
            disp_addr   = (k == 4) ? 19'd600 : 19'd5;
        end
        #2 rst_n = 1'b0;
        idle_inputs();
        #1 chk_all_zero("t6_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nv = 0; ndone = 0; nstall = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (disp_data_valid) nv++;
            if (clear_done) ndone++;
            if (clear_busy) nstall++;
        end
        chk("t6_no_stale_valid", nv, 0);
        chk("t6_no_done", ndone, 0);
        chk("t6_no_busy", nstall, 0);

        // Random traffic against the model.
        for (int ph = 0; ph < 4; ph++) begin
            rd_pct = (ph == 0) ? 20 : (ph == 1) ? 60 : (ph == 2) ? 95 : 100;
            wr_pct = 50;
            for (int k = 0; k < 1000; k++) begin
                @(negedge clk);
                if (!write_en || frame_write_valid) begin
                    write_en   = ($urandom_range(0, 99) < wr_pct);
                    frame_addr = ($urandom_range(0, 15) == 0) ?
                                 19'($urandom_range(FB_DEPTH, FB_DEPTH + 100)) :
                                 19'($urandom_range(0, FB_DEPTH - 1));
                    frame_data = 24'($urandom);
                end
                disp_req    = ($urandom_range(0, 99) < rd_pct);
                disp_addr   = ($urandom_range(0, 15) == 0) ?
                              19'($urandom_range(FB_DEPTH, FB_DEPTH + 100)) :
                              19'($urandom_range(0, FB_DEPTH - 1));
                clear_start = ($urandom_range(0, 799) == 0);
            end
        end
        @(negedge clk);
        idle_inputs();
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
